spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI word-transfer sequencer: moves cmd_len 32-bit words between a shared buffer and an SPI engine.
// Optional word timeout is compiled in with `define SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl #(
    parameter int BUF_DEPTH = 42,
    parameter int CS_GAP    = 2,
    parameter int TO_CYCLES = 1023
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_base,
    input  logic [5:0] cmd_len,
    output logic [7:0] buf_adr,
    output logic       buf_we,
    output logic       spi_start,
    input  logic       spi_done,
    output logic       spi_csn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    if (CS_GAP < 1) begin : g_cs_gap_chk
        $error("CS_GAP must be at least 1");
    end
    if (TO_CYCLES < 2) begin : g_to_chk
        $error("TO_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, STORE, GAP, FIN} state_t;

    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_t        state_q, state_d;
    logic          wr_q, wr_d;
    logic [7:0]    adr_q, adr_d;
    logic [5:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;
    logic          rdy_q;
    logic          cmd_ok;
    logic          word_end;

`ifdef SPI_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    logic [TW-1:0] to_q, to_d;
    logic          tmo_q, tmo_d;
`endif

    // Range check uses a 9-bit sum so a large base never wraps into a legal range.
    assign cmd_ok = (cmd_len != 6'd0) &&
                    (({1'b0, cmd_base} + 9'(cmd_len)) <= 9'(BUF_DEPTH));

    // rdy_q holds cmd_ready low until the first clock edge after reset releases.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            adr_q   <= 8'd0;
            rem_q   <= 6'd0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
            to_q    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q <= state_d;
            wr_q    <= wr_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
            to_q    <= to_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d  = state_q;
        wr_d     = wr_q;
        adr_d    = adr_q;
        rem_d    = rem_q;
        gap_d    = gap_q;
        err_d    = 1'b0;
        word_end = 1'b0;
`ifdef SPI_XFER_TIMEOUT_EN
        to_d     = to_q;
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    if (cmd_ok) begin
                        state_d = SETUP;
                        wr_d    = cmd_wr;
                        adr_d   = cmd_base;
                        rem_d   = cmd_len;
`ifdef SPI_XFER_TIMEOUT_EN
                        tmo_d   = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: state_d = START;
            START: begin
                state_d = WAIT;
`ifdef SPI_XFER_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            WAIT: begin
                if (spi_done) begin
                    if (wr_q) word_end = 1'b1;
                    else      state_d  = STORE;
                end
`ifdef SPI_XFER_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    state_d = GAP;
                    gap_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
`endif
            end
            STORE: word_end = 1'b1;
            GAP: begin
                if (gap_q == GAP_LAST) state_d = FIN;
                else                   gap_d   = gap_q + GW'(1);
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (word_end) begin
            adr_d = adr_q + 8'd1;
            rem_d = rem_q - 6'd1;
            if (rem_q == 6'd1) begin
                state_d = GAP;
                gap_d   = '0;
            end else begin
                state_d = START;
            end
        end
    end

    // Outputs decode the state register so reset forces them idle asynchronously.
    always_comb begin
        cmd_ready = (state_q == IDLE) && rdy_q;
        busy      = (state_q != IDLE);
        spi_start = (state_q == START);
        buf_we    = (state_q == STORE);
        spi_csn   = (state_q == IDLE) || (state_q == GAP) || (state_q == FIN);
        buf_adr   = adr_q;
        err       = err_q;
`ifdef SPI_XFER_TIMEOUT_EN
        done      = (state_q == FIN) && !tmo_q;
`else
        done      = (state_q == FIN);
`endif
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Randomized bench for spi_xfer_ctrl: a transaction-level model predicts accept/reject,
// the word address sequence, buffer writes and the chip-select gap for every command.
module tb_spi_xfer_ctrl;

    localparam int BUF_DEPTH = 42;
    localparam int CS_GAP    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_base = 8'd0;
    logic [5:0] cmd_len = 6'd0;
    logic [7:0] buf_adr;
    logic       buf_we;
    logic       spi_start;
    logic       spi_done = 1'b0;
    logic       spi_csn;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    spi_xfer_ctrl #(
        .BUF_DEPTH(BUF_DEPTH),
        .CS_GAP   (CS_GAP),
        .TO_CYCLES(1023)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_base (cmd_base),
        .cmd_len  (cmd_len),
        .buf_adr  (buf_adr),
        .buf_we   (buf_we),
        .spi_start(spi_start),
        .spi_done (spi_done),
        .spi_csn  (spi_csn),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One command end to end. dly = 0 picks a random spi_done latency per word.
    task automatic run_cmd(input bit wr, input int base, input int len, input int dly, input bit noise);
        int  q_start[$];
        int  q_we[$];
        bit  exp_ok;
        int  cd, gap_hi, low_after_gap, errs, hits;
        bit  got_done;

        exp_ok = (len != 0) && (base + len <= BUF_DEPTH);
        @(negedge clk);
        check("ready_idle", cmd_ready, 1);
        if (noise) begin
            spi_done = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
            check("stray_done_busy", busy, 0);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_base  = 8'(base);
        cmd_len   = 6'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_base  = 8'($urandom);
        cmd_len   = 6'($urandom);
        cmd_wr    = 1'($urandom);

        if (!exp_ok) begin
            check("rej_err", err, 1);
            check("rej_busy", busy, 0);
            check("rej_csn", spi_csn, 1);
            hits = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (err || spi_start || !spi_csn || busy) hits++;
            end
            check("rej_quiet", hits, 0);
            return;
        end

        check("acc_err", err, 0);
        check("acc_busy", busy, 1);
        check("acc_csn", spi_csn, 0);
        check("acc_adr", buf_adr, base);
        check("acc_start", spi_start, 0);
        @(negedge clk);
        check("first_start_lat", spi_start, 1);

        cd = 0; gap_hi = 0; low_after_gap = 0; errs = 0; got_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            cmd_valid = 1'b0;
            spi_done  = 1'b0;
            if (spi_start) begin
                q_start.push_back(int'(buf_adr));
                cd = (dly != 0) ? dly : int'($urandom_range(1, 6));
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) spi_done = 1'b1;
            end
            if (buf_we) q_we.push_back(int'(buf_adr));
            if (err) errs++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (spi_csn) gap_hi++;
            else if (gap_hi > 0) low_after_gap++;
            if (noise && $urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'($urandom);
                cmd_base  = 8'($urandom);
                cmd_len   = 6'($urandom);
            end
        end
        cmd_valid = 1'b0;
        spi_done  = 1'b0;

        check("done_seen", got_done, 1);
        check("no_err", errs, 0);
        check("cs_gap_len", gap_hi, CS_GAP);
        check("csn_no_relow", low_after_gap, 0);
        check("start_count", q_start.size(), len);
        for (int i = 0; i < q_start.size() && i < len; i++)
            check("start_adr", q_start[i], base + i);
        check("we_count", q_we.size(), wr ? 0 : len);
        for (int i = 0; i < q_we.size() && i < len; i++)
            check("we_adr", q_we[i], base + i);

        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_ready", cmd_ready, 1);
    endtask

    // Reset during the third WAIT of a five-word write.
    task automatic reset_mid();
        int  starts, cd, hits;
        bit  reached;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_base = 8'd5; cmd_len = 6'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        starts = 0; cd = 0; reached = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            spi_done = 1'b0;
            if (spi_start) begin
                starts++;
                cd = 3;
                if (starts == 3) begin
                    reached = 1'b1;
                    break;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) spi_done = 1'b1;
            end
        end
        spi_done = 1'b0;
        check("rst_third_start", reached, 1);
        @(negedge clk);
        check("rst_in_wait_csn", spi_csn, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_csn", spi_csn, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_ready", cmd_ready, 0);
        check("rst_async_adr", buf_adr, 0);
        check("rst_async_done", done, 0);
        check("rst_async_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("rst_ready_rise", cmd_ready, 1);
            if (done || err || spi_start || busy) hits++;
        end
        check("rst_no_activity", hits, 0);
    endtask

    initial begin
        int base, len;
        bit wr;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_csn", spi_csn, 1);
        check("reset_ready", cmd_ready, 0);
        check("reset_adr", buf_adr, 0);
        check("reset_we", buf_we, 0);
        check("reset_start", spi_start, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        check("ready_after_edge", cmd_ready, 1);

        run_cmd(1'b1, 0, 4, 10, 1'b0);
        run_cmd(1'b0, 40, 2, 0, 1'b0);
        run_cmd(1'b1, 40, 3, 0, 1'b0);
        run_cmd(1'b0, 12, 0, 0, 1'b0);
        run_cmd(1'b0, 3, 3, 0, 1'b1);
        reset_mid();
        run_cmd(1'b0, 41, 1, 0, 1'b0);
        run_cmd(1'b1, 42, 1, 0, 1'b0);
        run_cmd(1'b1, 37, 5, 1, 1'b1);
        run_cmd(1'b0, 0, 42, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            wr   = 1'($urandom);
            base = int'($urandom_range(0, 50));
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                                : int'($urandom_range(1, 8));
            run_cmd(wr, base, len, 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
